// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined RV32I control unit.
package ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  localparam logic [1:0] JmpNone = 2'b00;
  localparam logic [1:0] JmpJal  = 2'b01;
  localparam logic [1:0] JmpJalr = 2'b10;

  localparam logic [1:0] FwdRf    = 2'b00;
  localparam logic [1:0] FwdExMem = 2'b10;
  localparam logic [1:0] FwdMemWb = 2'b01;

  localparam int unsigned ExCtrlW  = 3;
  localparam int unsigned MemCtrlW = 3;
  localparam int unsigned WbCtrlW  = 3;
  localparam int unsigned JumpW    = 2;
  localparam int unsigned FwdW     = 2;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundles plus register-usage flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic             [31:0] instr_i,
  input  logic                    valid_i,
  output ex_ctrl_t                ex_ctrl_o,
  output logic       [JumpW-1:0]  jump_o,
  output mem_ctrl_t               mem_ctrl_o,
  output wb_ctrl_t                wb_ctrl_o,
  output logic                    rs1_used_o,
  output logic                    rs2_used_o,
  output logic                    rd_used_o
);

  always_comb begin
    ex_ctrl_o  = '0;
    jump_o     = JmpNone;
    mem_ctrl_o = '0;
    wb_ctrl_o  = '0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    rd_used_o  = 1'b0;
    if (valid_i) begin
      case (instr_i[6:0])
        OpR: begin
          ex_ctrl_o.alu_op    = 2'b10;
          wb_ctrl_o.reg_write = 1'b1;
          wb_ctrl_o.wb_sel    = WbAlu;
          rs1_used_o          = 1'b1;
          rs2_used_o          = 1'b1;
          rd_used_o           = 1'b1;
        end
        OpImm: begin
          ex_ctrl_o.alu_op    = 2'b10;
          ex_ctrl_o.alu_src   = 1'b1;
          wb_ctrl_o.reg_write = 1'b1;
          wb_ctrl_o.wb_sel    = WbAlu;
          rs1_used_o          = 1'b1;
          rd_used_o           = 1'b1;
        end
        OpLoad: begin
          ex_ctrl_o.alu_op     = 2'b00;
          ex_ctrl_o.alu_src    = 1'b1;
          mem_ctrl_o.mem_read  = 1'b1;
          wb_ctrl_o.reg_write  = 1'b1;
          wb_ctrl_o.wb_sel     = WbMem;
          rs1_used_o           = 1'b1;
          rd_used_o            = 1'b1;
        end
        OpStore: begin
          ex_ctrl_o.alu_src    = 1'b1;
          mem_ctrl_o.mem_write = 1'b1;
          rs1_used_o           = 1'b1;
          rs2_used_o           = 1'b1;
        end
        OpBranch: begin
          ex_ctrl_o.alu_op  = 2'b01;
          mem_ctrl_o.branch = 1'b1;
          rs1_used_o        = 1'b1;
          rs2_used_o        = 1'b1;
        end
        OpJal: begin
          ex_ctrl_o.alu_op    = 2'b11;
          jump_o              = JmpJal;
          wb_ctrl_o.reg_write = 1'b1;
          wb_ctrl_o.wb_sel    = WbPc4;
          rd_used_o           = 1'b1;
        end
        OpJalr: begin
          ex_ctrl_o.alu_src   = 1'b1;
          jump_o              = JmpJalr;
          wb_ctrl_o.reg_write = 1'b1;
          wb_ctrl_o.wb_sel    = WbPc4;
          rs1_used_o          = 1'b1;
          rd_used_o           = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: ID/EX, EX/MEM, MEM/WB control registers with load-use
// hazard detection, bubble insertion and EX-stage forwarding selects.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          HAZARD_EN  = 1'b1,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           instr_i,
  input  logic                  id_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [ExCtrlW-1:0]    ex_ctrl_o,
  output logic [JumpW-1:0]      ex_jump_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [MemCtrlW-1:0]   mem_ctrl_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic [WbCtrlW-1:0]    wb_ctrl_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  hazard_o,
  output logic [FwdW-1:0]       fwd_a_o,
  output logic [FwdW-1:0]       fwd_b_o
);

  ex_ctrl_t              dec_ex;
  logic [JumpW-1:0]      dec_jump;
  mem_ctrl_t             dec_mem;
  wb_ctrl_t              dec_wb;
  logic                  dec_rs1_used, dec_rs2_used, dec_rd_used;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic                  hazard;
  logic                  kill_id;

  // ID/EX
  ex_ctrl_t              ex_ctrl_q;
  logic [JumpW-1:0]      ex_jump_q;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  mem_ctrl_t             ex_mem_q;
  wb_ctrl_t              ex_wb_q;
  // EX/MEM
  mem_ctrl_t             mem_ctrl_q;
  wb_ctrl_t              mem_wb_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  // MEM/WB
  wb_ctrl_t              wb_ctrl_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic unused_instr;
  assign unused_instr = ^{instr_i[31:25], instr_i[14:12]};

  ctrl_decode u_decode (
    .instr_i   (instr_i),
    .valid_i   (id_valid_i),
    .ex_ctrl_o (dec_ex),
    .jump_o    (dec_jump),
    .mem_ctrl_o(dec_mem),
    .wb_ctrl_o (dec_wb),
    .rs1_used_o(dec_rs1_used),
    .rs2_used_o(dec_rs2_used),
    .rd_used_o (dec_rd_used)
  );

  // Unused tags are zeroed so a stale field can never match a live rd.
  always_comb begin
    id_rs1 = dec_rs1_used ? REG_ADDR_W'(instr_i[19:15]) : '0;
    id_rs2 = dec_rs2_used ? REG_ADDR_W'(instr_i[24:20]) : '0;
    id_rd  = dec_rd_used  ? REG_ADDR_W'(instr_i[11:7])  : '0;
    hazard = HAZARD_EN && ex_mem_q.mem_read && (ex_rd_q != '0) &&
             ((id_rs1 == ex_rd_q) || (id_rs2 == ex_rd_q));
    kill_id = flush_i || hazard;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_ctrl_q  <= '0;
      ex_jump_q  <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_mem_q   <= '0;
      ex_wb_q    <= '0;
      mem_ctrl_q <= '0;
      mem_wb_q   <= '0;
      mem_rd_q   <= '0;
      wb_ctrl_q  <= '0;
      wb_rd_q    <= '0;
    end else if (!stall_i) begin
      if (kill_id) begin
        ex_ctrl_q <= '0;
        ex_jump_q <= '0;
        ex_rs1_q  <= '0;
        ex_rs2_q  <= '0;
        ex_rd_q   <= '0;
        ex_mem_q  <= '0;
        ex_wb_q   <= '0;
      end else begin
        ex_ctrl_q <= dec_ex;
        ex_jump_q <= dec_jump;
        ex_rs1_q  <= id_rs1;
        ex_rs2_q  <= id_rs2;
        ex_rd_q   <= id_rd;
        ex_mem_q  <= dec_mem;
        ex_wb_q   <= dec_wb;
      end
      mem_ctrl_q <= ex_mem_q;
      mem_wb_q   <= ex_wb_q;
      mem_rd_q   <= ex_rd_q;
      wb_ctrl_q  <= mem_wb_q;
      wb_rd_q    <= mem_rd_q;
    end
  end

  function automatic logic [FwdW-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (mem_wb_q.reg_write && (mem_rd_q != '0) && (mem_rd_q == rs)) begin
      return FwdExMem;
    end else if (wb_ctrl_q.reg_write && (wb_rd_q != '0) && (wb_rd_q == rs)) begin
      return FwdMemWb;
    end
    return FwdRf;
  endfunction

  assign ex_ctrl_o  = ex_ctrl_q;
  assign ex_jump_o  = ex_jump_q;
  assign ex_rs1_o   = ex_rs1_q;
  assign ex_rs2_o   = ex_rs2_q;
  assign ex_rd_o    = ex_rd_q;
  assign mem_ctrl_o = mem_ctrl_q;
  assign mem_rd_o   = mem_rd_q;
  assign wb_ctrl_o  = wb_ctrl_q;
  assign wb_rd_o    = wb_rd_q;
  assign hazard_o   = hazard;
  assign fwd_a_o    = FWD_EN ? fwd_sel(ex_rs1_q) : FwdRf;
  assign fwd_b_o    = FWD_EN ? fwd_sel(ex_rs2_q) : FwdRf;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized and directed bench for ctrl_pipe against an in-bench instruction-flow model.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        id_valid, stall, flush;
  logic [2:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic [1:0]  ex_jump, fwd_a, fwd_b;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        hazard;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_ADDR_W(5), .HAZARD_EN(1'b1), .FWD_EN(1'b1)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .instr_i   (instr),
    .id_valid_i(id_valid),
    .stall_i   (stall),
    .flush_i   (flush),
    .ex_ctrl_o (ex_ctrl),
    .ex_jump_o (ex_jump),
    .ex_rs1_o  (ex_rs1),
    .ex_rs2_o  (ex_rs2),
    .ex_rd_o   (ex_rd),
    .mem_ctrl_o(mem_ctrl),
    .mem_rd_o  (mem_rd),
    .wb_ctrl_o (wb_ctrl),
    .wb_rd_o   (wb_rd),
    .hazard_o  (hazard),
    .fwd_a_o   (fwd_a),
    .fwd_b_o   (fwd_b)
  );

  // What one instruction means, in the terms of the decode table.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic [1:0] jump;
    logic       branch, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rs1, rs2, rd;
  } m_t;

  m_t pipe [3];  // 0 = in EX, 1 = in MEM, 2 = in WB

  function automatic m_t model_dec(input logic [31:0] ins, input logic v);
    m_t m = '0;
    bit u1 = 0, u2 = 0, ud = 0;
    if (v) begin
      case (ins[6:0])
        7'b0110011: begin m.reg_write = 1; m.alu_op = 2'b10; u1 = 1; u2 = 1; ud = 1; end
        7'b0010011: begin m.reg_write = 1; m.alu_src = 1; m.alu_op = 2'b10; u1 = 1; ud = 1; end
        7'b0000011: begin
          m.reg_write = 1; m.alu_src = 1; m.mem_read = 1; m.wb_sel = 2'b01;
          u1 = 1; ud = 1;
        end
        7'b0100011: begin m.alu_src = 1; m.mem_write = 1; u1 = 1; u2 = 1; end
        7'b1100011: begin m.branch = 1; m.alu_op = 2'b01; u1 = 1; u2 = 1; end
        7'b1101111: begin
          m.jump = 2'b01; m.reg_write = 1; m.wb_sel = 2'b10; m.alu_op = 2'b11; ud = 1;
        end
        7'b1100111: begin
          m.jump = 2'b10; m.reg_write = 1; m.wb_sel = 2'b10; m.alu_src = 1; u1 = 1; ud = 1;
        end
        default: ;
      endcase
    end
    m.rs1 = u1 ? ins[19:15] : 5'd0;
    m.rs2 = u2 ? ins[24:20] : 5'd0;
    m.rd  = ud ? ins[11:7]  : 5'd0;
    return m;
  endfunction

  function automatic logic model_haz(input m_t c);
    return pipe[0].mem_read && pipe[0].rd != 0 && (c.rs1 == pipe[0].rd || c.rs2 == pipe[0].rd);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (pipe[1].reg_write && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].reg_write && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
    end else if (!stall) begin
      pipe[0] <= (flush || model_haz(model_dec(instr, id_valid))) ? '0 : model_dec(instr, id_valid);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ctrl", ex_ctrl, {pipe[0].alu_op, pipe[0].alu_src});
      check("ex_jump", ex_jump, pipe[0].jump);
      check("ex_rs1", ex_rs1, pipe[0].rs1);
      check("ex_rs2", ex_rs2, pipe[0].rs2);
      check("ex_rd", ex_rd, pipe[0].rd);
      check("mem_ctrl", mem_ctrl, {pipe[1].branch, pipe[1].mem_read, pipe[1].mem_write});
      check("mem_rd", mem_rd, pipe[1].rd);
      check("wb_ctrl", wb_ctrl, {pipe[2].reg_write, pipe[2].wb_sel});
      check("wb_rd", wb_rd, pipe[2].rd);
      check("hazard", hazard, model_haz(model_dec(instr, id_valid)));
      check("fwd_a", fwd_a, model_fwd(pipe[0].rs1));
      check("fwd_b", fwd_b, model_fwd(pipe[0].rs2));
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2, input bit sub);
    return {sub ? 7'b0100000 : 7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1);
    return {12'h005, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs1, rs2);
    return {7'b0, rs2, rs1, 3'b010, 5'd4, 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_br(input logic [4:0] rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b01000, 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'h0A5A3, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, rs1);
    return {12'h010, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                      input logic r);
    @(posedge clk);
    #1;
    rst_n = r; instr = ins; id_valid = v; stall = st; flush = fl;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: return enc_r(a, b, c, 0);
      1: return enc_i(a, b);
      2: return enc_lw(a, b);
      3: return enc_sw(b, c);
      4: return enc_br(b, c);
      5: return enc_jal(a);
      6: return enc_jalr(a, b);
      7: return enc_r(a, b, c, 1);
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] snap;
  logic [31:0] add11;

  initial begin
    rst_n = 0; instr = enc_r(3, 1, 2, 0); id_valid = 1; stall = 0; flush = 0;
    @(posedge clk);
    #1 chk_en = 1;

    // Reset held with a valid instruction in ID
    step(enc_r(3, 1, 2, 0), 1, 0, 0, 0);
    check("rst ex_ctrl", ex_ctrl, 0);
    check("rst wb_ctrl", wb_ctrl, 0);
    check("rst hazard", hazard, 0);
    check("rst fwd", {fwd_a, fwd_b}, 0);

    step(enc_r(3, 1, 2, 0), 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("add ex_ctrl", ex_ctrl, 3'b100);
    check("add ex_rd", ex_rd, 3);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("add wb_ctrl", wb_ctrl, 3'b100);
    check("add wb_rd", wb_rd, 3);

    // Load-use: one bubble, then MEM/WB forwarding
    step(enc_lw(5, 1), 1, 0, 0, 1);
    step(enc_r(6, 5, 2, 0), 1, 0, 0, 1);
    check("lu hazard", hazard, 1);
    step(enc_r(6, 5, 2, 0), 1, 0, 0, 1);
    check("lu hazard drop", hazard, 0);
    check("lu bubble", ex_ctrl, 0);
    step(0, 0, 0, 0, 1);
    check("lu ex_rd", ex_rd, 6);
    check("lu fwd_a", fwd_a, 2'b01);

    // No false hazards
    step(enc_lw(5, 1), 1, 0, 0, 1);
    step(enc_jal(6), 1, 0, 0, 1);
    check("jal no hazard", hazard, 0);
    step(enc_lw(0, 1), 1, 0, 0, 1);
    step(enc_r(7, 0, 0, 0), 1, 0, 0, 1);
    check("x0 no hazard", hazard, 0);

    // EX/MEM beats MEM/WB
    step(enc_r(4, 1, 2, 0), 1, 0, 0, 1);
    step(enc_r(4, 3, 5, 0), 1, 0, 0, 1);
    step(enc_r(8, 4, 4, 1), 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("prio fwd_a", fwd_a, 2'b10);
    check("prio fwd_b", fwd_b, 2'b10);

    // Flushed store never reaches MEM
    step(enc_sw(1, 2), 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      check("flush mem_ctrl", mem_ctrl, 0);
    end

    // Stall with a pending load-use: hold wins, hazard persists
    add11 = enc_r(11, 10, 1, 0);
    step(enc_r(9, 1, 2, 0), 1, 0, 0, 1);
    step(enc_lw(10, 9), 1, 0, 0, 1);
    step(add11, 1, 1, 0, 1);
    check("stall hazard", hazard, 1);
    snap = {ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd, fwd_a, fwd_b};
    for (int i = 0; i < 2; i++) begin
      step(add11, 1, 1, 0, 1);
      check("stall hold", {ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd, fwd_a, fwd_b},
            snap);
      check("stall hazard", hazard, 1);
    end
    step(add11, 1, 0, 0, 1);
    check("release hazard", hazard, 1);
    step(add11, 1, 0, 0, 1);
    check("release hazard drop", hazard, 0);
    check("release bubble", ex_ctrl, 0);

    // Illegal opcode and invalid slot decode as bubbles
    step(32'hFFFF_FFFF, 1, 0, 0, 1);
    step(enc_r(3, 1, 2, 0), 0, 0, 0, 1);
    check("illegal ex", {ex_ctrl, ex_jump, ex_rd}, 0);
    step(0, 0, 0, 0, 1);
    check("illegal mem", {mem_ctrl, mem_rd}, 0);
    check("invalid ex", {ex_ctrl, ex_jump, ex_rd}, 0);
    step(0, 0, 0, 0, 1);
    check("illegal wb", {wb_ctrl, wb_rd}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
